// File: rtl/sys_ctrl.sv
// Command sequencer between UART RX, the register file, the ALU and the UART TX FIFO.
// Byte frames become single-cycle register-file strobes or ALU runs whose results are sent back over TX.
module sys_ctrl #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8,
   parameter int ALU_WIDTH  = 16
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] RX_P_DATA,
   input  logic                  RX_D_VLD,
   input  logic [DATA_WIDTH-1:0] RF_RdData,
   input  logic                  RF_RdData_Valid,
   input  logic [ALU_WIDTH-1:0]  ALU_OUT,
   input  logic                  ALU_OUT_VLD,
   input  logic                  FIFO_FULL,
   output logic [ADDR_WIDTH-1:0] RF_Address,
   output logic                  RF_WrEn,
   output logic                  RF_RdEn,
   output logic [DATA_WIDTH-1:0] RF_WrData,
   output logic [3:0]            ALU_FUN,
   output logic                  ALU_EN,
   output logic                  CLK_GATE_EN,
   output logic [DATA_WIDTH-1:0] TX_P_DATA,
   output logic                  TX_D_VLD
);

   localparam logic [DATA_WIDTH-1:0] OP_WRITE   = DATA_WIDTH'(8'hAA);
   localparam logic [DATA_WIDTH-1:0] OP_READ    = DATA_WIDTH'(8'hBB);
   localparam logic [DATA_WIDTH-1:0] OP_ALU_OPS = DATA_WIDTH'(8'hCC);
   localparam logic [DATA_WIDTH-1:0] OP_ALU     = DATA_WIDTH'(8'hDD);

   typedef enum logic [3:0] {
      S_IDLE,
      S_WR_ADDR,
      S_WR_DATA,
      S_RD_ADDR,
      S_RD_WAIT,
      S_OPA,
      S_OPB,
      S_ALU_FUN,
      S_ALU_WAIT,
      S_TX_LSB,
      S_TX_MSB,
      S_TX_RD
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] rfAddress_q, rfAddress_d;
   logic [ADDR_WIDTH-1:0] wrAddr_q, wrAddr_d;
   logic                  rfWrEn_q, rfWrEn_d;
   logic                  rfRdEn_q, rfRdEn_d;
   logic [DATA_WIDTH-1:0] rfWrData_q, rfWrData_d;
   logic [DATA_WIDTH-1:0] rdData_q, rdData_d;
   logic [DATA_WIDTH-1:0] txData_q, txData_d;
   logic                  txVld_q, txVld_d;
   logic [3:0]            aluFun_q, aluFun_d;
   logic                  aluEn_q, aluEn_d;
   logic                  clkGateEn_q, clkGateEn_d;
   logic [ALU_WIDTH-1:0]  aluRes_q, aluRes_d;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // In a TX state, txVld_q high means this state's byte already left on the entry edge.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (RX_D_VLD) begin
               case (RX_P_DATA)
                  OP_WRITE:   state_d = S_WR_ADDR;
                  OP_READ:    state_d = S_RD_ADDR;
                  OP_ALU_OPS: state_d = S_OPA;
                  OP_ALU:     state_d = S_ALU_FUN;
                  default:    state_d = S_IDLE;
               endcase
            end
         end
         S_WR_ADDR:  if (RX_D_VLD) state_d = S_WR_DATA;
         S_WR_DATA:  if (RX_D_VLD) state_d = S_IDLE;
         S_RD_ADDR:  if (RX_D_VLD) state_d = S_RD_WAIT;
         S_RD_WAIT:  if (RF_RdData_Valid) state_d = S_TX_RD;
         S_TX_RD:    if (txVld_q || !FIFO_FULL) state_d = S_IDLE;
         S_OPA:      if (RX_D_VLD) state_d = S_OPB;
         S_OPB:      if (RX_D_VLD) state_d = S_ALU_FUN;
         S_ALU_FUN:  if (RX_D_VLD) state_d = S_ALU_WAIT;
         S_ALU_WAIT: if (ALU_OUT_VLD) state_d = S_TX_LSB;
         S_TX_LSB:   if (txVld_q) state_d = S_TX_MSB;
         S_TX_MSB:   if (txVld_q || !FIFO_FULL) state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   always_comb begin
      rfAddress_d = rfAddress_q;
      wrAddr_d    = wrAddr_q;
      rfWrEn_d    = 1'b0;
      rfRdEn_d    = 1'b0;
      rfWrData_d  = rfWrData_q;
      rdData_d    = rdData_q;
      txData_d    = txData_q;
      txVld_d     = 1'b0;
      aluFun_d    = aluFun_q;
      aluEn_d     = 1'b0;
      aluRes_d    = aluRes_q;
      clkGateEn_d = (state_d == S_ALU_FUN) || (state_d == S_ALU_WAIT);
      case (state_q)
         S_WR_ADDR: begin
            if (RX_D_VLD) wrAddr_d = RX_P_DATA[ADDR_WIDTH-1:0];
         end
         S_WR_DATA: begin
            if (RX_D_VLD) begin
               rfAddress_d = wrAddr_q;
               rfWrData_d  = RX_P_DATA;
               rfWrEn_d    = 1'b1;
            end
         end
         S_RD_ADDR: begin
            if (RX_D_VLD) begin
               rfAddress_d = RX_P_DATA[ADDR_WIDTH-1:0];
               rfRdEn_d    = 1'b1;
            end
         end
         S_RD_WAIT: begin
            if (RF_RdData_Valid) begin
               rdData_d = RF_RdData;
               if (!FIFO_FULL) begin
                  txVld_d  = 1'b1;
                  txData_d = RF_RdData;
               end
            end
         end
         S_TX_RD: begin
            if (!txVld_q && !FIFO_FULL) begin
               txVld_d  = 1'b1;
               txData_d = rdData_q;
            end
         end
         S_OPA: begin
            if (RX_D_VLD) begin
               rfAddress_d = ADDR_WIDTH'(0);
               rfWrData_d  = RX_P_DATA;
               rfWrEn_d    = 1'b1;
            end
         end
         S_OPB: begin
            if (RX_D_VLD) begin
               rfAddress_d = ADDR_WIDTH'(1);
               rfWrData_d  = RX_P_DATA;
               rfWrEn_d    = 1'b1;
            end
         end
         S_ALU_FUN: begin
            if (RX_D_VLD) begin
               aluFun_d = RX_P_DATA[3:0];
               aluEn_d  = 1'b1;
            end
         end
         S_ALU_WAIT: begin
            if (ALU_OUT_VLD) begin
               aluRes_d = ALU_OUT;
               if (!FIFO_FULL) begin
                  txVld_d  = 1'b1;
                  txData_d = ALU_OUT[DATA_WIDTH-1:0];
               end
            end
         end
         S_TX_LSB: begin
            if (!FIFO_FULL) begin
               txVld_d  = 1'b1;
               txData_d = txVld_q ? aluRes_q[ALU_WIDTH-1:DATA_WIDTH] : aluRes_q[DATA_WIDTH-1:0];
            end
         end
         S_TX_MSB: begin
            if (!txVld_q && !FIFO_FULL) begin
               txVld_d  = 1'b1;
               txData_d = aluRes_q[ALU_WIDTH-1:DATA_WIDTH];
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         rfAddress_q <= '0;
         wrAddr_q    <= '0;
         rfWrEn_q    <= 1'b0;
         rfRdEn_q    <= 1'b0;
         rfWrData_q  <= '0;
         rdData_q    <= '0;
         txData_q    <= '0;
         txVld_q     <= 1'b0;
         aluFun_q    <= '0;
         aluEn_q     <= 1'b0;
         aluRes_q    <= '0;
         clkGateEn_q <= 1'b0;
      end else begin
         rfAddress_q <= rfAddress_d;
         wrAddr_q    <= wrAddr_d;
         rfWrEn_q    <= rfWrEn_d;
         rfRdEn_q    <= rfRdEn_d;
         rfWrData_q  <= rfWrData_d;
         rdData_q    <= rdData_d;
         txData_q    <= txData_d;
         txVld_q     <= txVld_d;
         aluFun_q    <= aluFun_d;
         aluEn_q     <= aluEn_d;
         aluRes_q    <= aluRes_d;
         clkGateEn_q <= clkGateEn_d;
      end
   end

   assign RF_Address  = rfAddress_q;
   assign RF_WrEn     = rfWrEn_q;
   assign RF_RdEn     = rfRdEn_q;
   assign RF_WrData   = rfWrData_q;
   assign ALU_FUN     = aluFun_q;
   assign ALU_EN      = aluEn_q;
   assign CLK_GATE_EN = clkGateEn_q;
   assign TX_P_DATA   = txData_q;
   assign TX_D_VLD    = txVld_q;

endmodule

// File: tb/tb_sys_ctrl.sv
// Bench for sys_ctrl: drives command frames, stands in for the register file, ALU and TX FIFO,
// and scores every strobe against expectation queues filled when each frame is sent.
`timescale 1ns/1ps
module tb_sys_ctrl;

   logic       CLK = 1'b0;
   logic       RST;
   logic [7:0] RX_P_DATA;
   logic       RX_D_VLD;
   logic [7:0] RF_RdData = 8'h00;
   logic       RF_RdData_Valid = 1'b0;
   logic [15:0] ALU_OUT = 16'h0000;
   logic       ALU_OUT_VLD = 1'b0;
   logic       FIFO_FULL;
   logic [3:0] RF_Address;
   logic       RF_WrEn;
   logic       RF_RdEn;
   logic [7:0] RF_WrData;
   logic [3:0] ALU_FUN;
   logic       ALU_EN;
   logic       CLK_GATE_EN;
   logic [7:0] TX_P_DATA;
   logic       TX_D_VLD;

   logic [28:0] allOut;
   assign allOut = {RF_Address, RF_WrEn, RF_RdEn, RF_WrData, ALU_FUN, ALU_EN,
                    CLK_GATE_EN, TX_P_DATA, TX_D_VLD};

   logic [7:0]  txExp[$];
   logic [11:0] wrExp[$];
   logic [3:0]  rdExp[$];
   logic [3:0]  aluExp[$];

   int checks = 0;
   int errors = 0;
   int cycleCnt = 0;
   int lastRxCycle = 0;
   int lastWrCycle = 0;
   int lastRdCycle = 0;
   int lastTxCycle = 0;
   int prevTxCycle = 0;
   logic prevGate = 1'b0;

   logic [7:0]  rfMem [16] = '{default: 8'h00};
   logic [15:0] aluValue = 16'h0000;
   int          aluLatency = 3;

   sys_ctrl dut (
      .CLK             (CLK),
      .RST             (RST),
      .RX_P_DATA       (RX_P_DATA),
      .RX_D_VLD        (RX_D_VLD),
      .RF_RdData       (RF_RdData),
      .RF_RdData_Valid (RF_RdData_Valid),
      .ALU_OUT         (ALU_OUT),
      .ALU_OUT_VLD     (ALU_OUT_VLD),
      .FIFO_FULL       (FIFO_FULL),
      .RF_Address      (RF_Address),
      .RF_WrEn         (RF_WrEn),
      .RF_RdEn         (RF_RdEn),
      .RF_WrData       (RF_WrData),
      .ALU_FUN         (ALU_FUN),
      .ALU_EN          (ALU_EN),
      .CLK_GATE_EN     (CLK_GATE_EN),
      .TX_P_DATA       (TX_P_DATA),
      .TX_D_VLD        (TX_D_VLD)
   );

   initial forever #5 CLK = ~CLK;

   always @(posedge CLK) cycleCnt <= cycleCnt + 1;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] b);
      @(negedge CLK);
      RX_P_DATA   = b;
      RX_D_VLD    = 1'b1;
      lastRxCycle = cycleCnt;
      @(negedge CLK);
      RX_D_VLD    = 1'b0;
   endtask

   task automatic waitDone(input string tag);
      int n = 0;
      while ((txExp.size() + wrExp.size() + rdExp.size() + aluExp.size()) != 0 && n < 60) begin
         @(negedge CLK);
         n++;
      end
      checkOutput({tag, "_drain"}, 32'(txExp.size() + wrExp.size() + rdExp.size() + aluExp.size()), 32'd0);
      repeat (4) @(negedge CLK);
   endtask

   // Register file and ALU stand-ins: read data one cycle after RF_RdEn, ALU result aluLatency cycles after ALU_EN.
   initial begin : responder
      logic       rdReq;
      logic [3:0] rdReqAddr;
      int         aluCnt;
      rdReq = 1'b0;
      rdReqAddr = 4'h0;
      aluCnt = 0;
      forever begin
         @(negedge CLK);
         RF_RdData_Valid = rdReq;
         if (rdReq) RF_RdData = rfMem[rdReqAddr];
         rdReq     = RF_RdEn;
         rdReqAddr = RF_Address;
         if (RF_WrEn) rfMem[RF_Address] = RF_WrData;
         ALU_OUT_VLD = 1'b0;
         if (aluCnt > 0) begin
            aluCnt--;
            if (aluCnt == 0) begin
               ALU_OUT_VLD = 1'b1;
               ALU_OUT     = aluValue;
            end
         end
         if (ALU_EN) aluCnt = aluLatency;
      end
   end

   initial begin : monitor
      logic [11:0] expWr;
      logic [3:0]  expRd;
      logic [3:0]  expFun;
      logic [7:0]  expTx;
      forever begin
         @(negedge CLK);
         if (RF_WrEn) begin
            lastWrCycle = cycleCnt;
            checkOutput("wr_rd_exclusive", 32'(RF_RdEn), 32'd0);
            if (wrExp.size() == 0) begin
               checkOutput("wr_spurious", 32'(wrExp.size()), 32'd1);
            end else begin
               expWr = wrExp.pop_front();
               checkOutput("wr_addr_data", 32'({RF_Address, RF_WrData}), 32'(expWr));
            end
         end
         if (RF_RdEn) begin
            lastRdCycle = cycleCnt;
            if (rdExp.size() == 0) begin
               checkOutput("rd_spurious", 32'(rdExp.size()), 32'd1);
            end else begin
               expRd = rdExp.pop_front();
               checkOutput("rd_addr", 32'(RF_Address), 32'(expRd));
            end
         end
         if (ALU_EN) begin
            checkOutput("gate_at_en", 32'(CLK_GATE_EN), 32'd1);
            checkOutput("gate_before_en", 32'(prevGate), 32'd1);
            if (aluExp.size() == 0) begin
               checkOutput("alu_spurious", 32'(aluExp.size()), 32'd1);
            end else begin
               expFun = aluExp.pop_front();
               checkOutput("alu_fun", 32'(ALU_FUN), 32'(expFun));
            end
         end
         if (TX_D_VLD) begin
            prevTxCycle = lastTxCycle;
            lastTxCycle = cycleCnt;
            checkOutput("gate_in_tx", 32'(CLK_GATE_EN), 32'd0);
            if (txExp.size() == 0) begin
               checkOutput("tx_spurious", 32'(txExp.size()), 32'd1);
            end else begin
               expTx = txExp.pop_front();
               checkOutput("tx_byte", 32'(TX_P_DATA), 32'(expTx));
            end
         end
         prevGate = CLK_GATE_EN;
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: observed still running expected finished");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      int refCycle;
      RST       = 1'b0;
      RX_P_DATA = 8'h00;
      RX_D_VLD  = 1'b0;
      FIFO_FULL = 1'b0;
      repeat (3) @(negedge CLK);
      checkOutput("reset_outputs", 32'(allOut), 32'd0);
      RST = 1'b1;
      repeat (2) @(negedge CLK);

      $display("[TB] write then read RF[5]");
      wrExp.push_back({4'h5, 8'h3C});
      applyStimulus(8'hAA);
      applyStimulus(8'h05);
      applyStimulus(8'h3C);
      refCycle = lastRxCycle;
      waitDone("write5");
      checkOutput("wr_latency", 32'(lastWrCycle - refCycle), 32'd1);
      rdExp.push_back(4'h5);
      txExp.push_back(8'h3C);
      applyStimulus(8'hBB);
      applyStimulus(8'h05);
      refCycle = lastRxCycle;
      waitDone("read5");
      checkOutput("rd_en_latency", 32'(lastRdCycle - refCycle), 32'd1);
      checkOutput("rd_tx_latency", 32'(lastTxCycle - refCycle), 32'd3);

      $display("[TB] ALU with operands");
      aluValue   = 16'h0468;
      aluLatency = 3;
      wrExp.push_back({4'h0, 8'h12});
      wrExp.push_back({4'h1, 8'h34});
      aluExp.push_back(4'h2);
      txExp.push_back(8'h68);
      txExp.push_back(8'h04);
      applyStimulus(8'hCC);
      applyStimulus(8'h12);
      applyStimulus(8'h34);
      applyStimulus(8'h02);
      waitDone("alu_ops");
      checkOutput("msb_no_bubble", 32'(lastTxCycle - prevTxCycle), 32'd1);
      checkOutput("gate_off", 32'(CLK_GATE_EN), 32'd0);

      $display("[TB] ALU without operands");
      aluValue = 16'hA5C3;
      aluExp.push_back(4'h1);
      txExp.push_back(8'hC3);
      txExp.push_back(8'hA5);
      applyStimulus(8'hDD);
      applyStimulus(8'h01);
      waitDone("alu_only");

      $display("[TB] read back-pressure");
      FIFO_FULL = 1'b1;
      rdExp.push_back(4'h0);
      txExp.push_back(8'h12);
      applyStimulus(8'hBB);
      applyStimulus(8'h00);
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         checkOutput("bp_read_hold", 32'(TX_D_VLD), 32'd0);
      end
      FIFO_FULL = 1'b0;
      waitDone("bp_read");

      $display("[TB] ALU result back-pressure");
      aluValue  = 16'hBEEF;
      FIFO_FULL = 1'b1;
      aluExp.push_back(4'h7);
      txExp.push_back(8'hEF);
      txExp.push_back(8'hBE);
      applyStimulus(8'hDD);
      applyStimulus(8'h07);
      for (int i = 0; i < 8; i++) begin
         @(negedge CLK);
         checkOutput("bp_alu_hold", 32'(TX_D_VLD), 32'd0);
      end
      FIFO_FULL = 1'b0;
      waitDone("bp_alu");

      $display("[TB] illegal opcode and byte dropped in ALU_WAIT");
      applyStimulus(8'h55);
      waitDone("illegal");
      aluValue   = 16'h1357;
      aluLatency = 5;
      aluExp.push_back(4'h4);
      txExp.push_back(8'h57);
      txExp.push_back(8'h13);
      applyStimulus(8'hDD);
      applyStimulus(8'h04);
      applyStimulus(8'hAA);
      waitDone("drop");
      wrExp.push_back({4'h3, 8'h5A});
      applyStimulus(8'hAA);
      applyStimulus(8'h03);
      applyStimulus(8'h5A);
      waitDone("after_drop");
      rdExp.push_back(4'h3);
      txExp.push_back(8'h5A);
      applyStimulus(8'hBB);
      applyStimulus(8'h03);
      waitDone("readback3");

      $display("[TB] reset mid-frame");
      wrExp.push_back({4'h7, 8'hA5});
      applyStimulus(8'hAA);
      applyStimulus(8'h07);
      applyStimulus(8'hA5);
      waitDone("write7");
      applyStimulus(8'hAA);
      applyStimulus(8'h07);
      @(negedge CLK);
      #2 RST = 1'b0;
      @(negedge CLK);
      checkOutput("rst_frame_out0", 32'(allOut), 32'd0);
      @(negedge CLK);
      checkOutput("rst_frame_out1", 32'(allOut), 32'd0);
      RST = 1'b1;
      rdExp.push_back(4'h7);
      txExp.push_back(8'hA5);
      applyStimulus(8'hBB);
      applyStimulus(8'h07);
      waitDone("after_reset");

      $display("[TB] reset mid-ALU");
      aluValue   = 16'h6789;
      aluLatency = 6;
      aluExp.push_back(4'h9);
      applyStimulus(8'hDD);
      applyStimulus(8'h09);
      @(negedge CLK);
      checkOutput("gate_in_wait", 32'(CLK_GATE_EN), 32'd1);
      #2 RST = 1'b0;
      @(negedge CLK);
      checkOutput("rst_alu_out0", 32'(allOut), 32'd0);
      @(negedge CLK);
      RST = 1'b1;
      repeat (8) @(negedge CLK);
      waitDone("alu_abort");

      aluValue   = 16'h00FF;
      aluLatency = 2;
      aluExp.push_back(4'hF);
      txExp.push_back(8'hFF);
      txExp.push_back(8'h00);
      applyStimulus(8'hDD);
      applyStimulus(8'h0F);
      waitDone("final_alu");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
